// File: rtl/ball_motion.sv
// Frame-rate ball position engine: one position/motion update per frame_clk rising edge,
// steered by WASD keycodes, bouncing off screen edges, with a space-bar pause toggle.
module ball_motion #(
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int SIZE     = 4,
  parameter int STEP     = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       frame_tick
);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} mode_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [9:0] SIZE_V   = 10'(SIZE);
  localparam logic [9:0] X_HI     = 10'(X_MAX);
  localparam logic [9:0] X_LO     = 10'(X_MIN + SIZE);
  localparam logic [9:0] Y_HI     = 10'(Y_MAX);
  localparam logic [9:0] Y_LO     = 10'(Y_MIN + SIZE);
  localparam logic [9:0] X_RESET  = 10'(X_CENTER);
  localparam logic [9:0] Y_RESET  = 10'(Y_CENTER);
  localparam logic signed [9:0] STEP_POS = 10'(STEP);
  localparam logic signed [9:0] STEP_NEG = 10'(-STEP);

  logic [9:0]        ball_x_reg, ball_x_next;
  logic [9:0]        ball_y_reg, ball_y_next;
  logic signed [9:0] mot_x_reg, mot_x_next;
  logic signed [9:0] mot_y_reg, mot_y_next;
  logic [9:0]        x_edge, y_edge;
  logic              frame_clk_d_reg;
  logic [7:0]        key_prev_reg;
  logic              frame_tick_reg;
  logic              tick;
  mode_t             mode_reg, mode_next;

  assign tick = frame_clk & ~frame_clk_d_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_n) mode_reg <= RUN;
    else          mode_reg <= mode_next;
  end

  // A held space bar toggles once: key_prev only refreshes on ticks.
  always_comb begin
    mode_next = mode_reg;
    if (tick && keycode == KEY_SPACE && key_prev_reg != KEY_SPACE)
      mode_next = (mode_reg == RUN) ? PAUSED : RUN;
  end

  always_comb begin
    mot_x_next  = mot_x_reg;
    mot_y_next  = mot_y_reg;
    ball_x_next = ball_x_reg;
    ball_y_next = ball_y_reg;
    x_edge      = ball_x_reg + SIZE_V;
    y_edge      = ball_y_reg + SIZE_V;
    if (tick && mode_next == RUN) begin
      case (keycode)
        KEY_W:   begin mot_x_next = '0;       mot_y_next = STEP_NEG; end
        KEY_A:   begin mot_x_next = STEP_NEG; mot_y_next = '0;       end
        KEY_S:   begin mot_x_next = '0;       mot_y_next = STEP_POS; end
        KEY_D:   begin mot_x_next = STEP_POS; mot_y_next = '0;       end
        default: ;
      endcase
      // Edge bounce overrides the key, per axis, using the pre-update position.
      if (x_edge >= X_HI)          mot_x_next = STEP_NEG;
      else if (ball_x_reg <= X_LO) mot_x_next = STEP_POS;
      if (y_edge >= Y_HI)          mot_y_next = STEP_NEG;
      else if (ball_y_reg <= Y_LO) mot_y_next = STEP_POS;
      ball_x_next = ball_x_reg + $unsigned(mot_x_next);
      ball_y_next = ball_y_reg + $unsigned(mot_y_next);
    end
  end

  // frame_clk_d resets high so a strobe already high at release is not an edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ball_x_reg      <= X_RESET;
      ball_y_reg      <= Y_RESET;
      mot_x_reg       <= '0;
      mot_y_reg       <= '0;
      frame_clk_d_reg <= 1'b1;
      key_prev_reg    <= 8'h00;
      frame_tick_reg  <= 1'b0;
    end else begin
      ball_x_reg      <= ball_x_next;
      ball_y_reg      <= ball_y_next;
      mot_x_reg       <= mot_x_next;
      mot_y_reg       <= mot_y_next;
      frame_clk_d_reg <= frame_clk;
      frame_tick_reg  <= tick;
      if (tick) key_prev_reg <= keycode;
    end
  end

  assign BallX      = ball_x_reg;
  assign BallY      = ball_y_reg;
  assign Ball_size  = SIZE_V;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: stimulus pushes expected positions into a queue,
// a monitor pops and compares them on every frame_tick.
module tb_ball_motion;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, Ball_size;
  logic       frame_tick;

  int checks = 0;
  int fails = 0;
  int tick_count = 0;
  int n_pulses = 0;
  logic [19:0] exp_q[$];

  ball_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge Clk);
      if (frame_tick) begin
        tick_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_tick: actual x=%0d y=%0d required no tick", BallX, BallY);
        end else begin
          e = exp_q.pop_front();
          $display("tick %0d: x=%0d y=%0d (want %0d,%0d)", tick_count, BallX, BallY, e[19:10], e[9:0]);
          check("ball_x", int'(BallX), int'(e[19:10]));
          check("ball_y", int'(BallY), int'(e[9:0]));
        end
      end
    end
  end

  // Caller is aligned to a falling edge.
  task automatic pulse(input logic [7:0] key, input int ex, input int ey);
    logic [9:0] x10, y10;
    x10 = 10'(ex);
    y10 = 10'(ey);
    keycode = key;
    frame_clk = 1'b1;
    exp_q.push_back({x10, y10});
    n_pulses++;
    @(negedge Clk);
    check("tick_latency", int'(frame_tick), 1);
    @(negedge Clk);
    check("tick_width", int'(frame_tick), 0);
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex, ey;
    Reset_n = 1'b0;
    frame_clk = 1'b1;
    keycode = 8'h00;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("reset_x", int'(BallX), 320);
    check("reset_y", int'(BallY), 240);
    check("reset_size", int'(Ball_size), 4);
    check("reset_tick", int'(frame_tick), 0);
    check("no_tick_held_high", tick_count, 0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // D three times
    ex = 320; ey = 240;
    for (int i = 0; i < 3; i++) begin
      ex++;
      pulse(8'h07, ex, ey);
    end
    // D held to the right edge, then bounce alternation
    while (ex < 635) begin
      ex++;
      pulse(8'h07, ex, ey);
    end
    pulse(8'h07, 634, ey);
    pulse(8'h07, 635, ey);
    pulse(8'h07, 634, ey);
    pulse(8'h07, 635, ey);
    // A twice (first also bounced), W twice, A twice, no key twice
    pulse(8'h04, 634, 240);
    pulse(8'h04, 633, 240);
    pulse(8'h1A, 633, 239);
    pulse(8'h1A, 633, 238);
    pulse(8'h04, 632, 238);
    pulse(8'h04, 631, 238);
    pulse(8'h00, 630, 238);
    pulse(8'h00, 629, 238);
    // Pause, D ignored while paused, resume keeps prior (-1,0) motion
    pulse(8'h2C, 629, 238);
    for (int i = 0; i < 5; i++) pulse(8'h07, 629, 238);
    pulse(8'h00, 629, 238);
    pulse(8'h2C, 628, 238);
    // Space held four ticks: one toggle only
    pulse(8'h00, 627, 238);
    for (int i = 0; i < 4; i++) pulse(8'h2C, 627, 238);
    pulse(8'h00, 627, 238);
    pulse(8'h2C, 626, 238);
    pulse(8'h07, 627, 238);

    // Reset coincident with a tick while moving (+1,0)
    keycode = 8'h07;
    frame_clk = 1'b1;
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midreset_x", int'(BallX), 320);
    check("midreset_y", int'(BallY), 240);
    check("midreset_tick", int'(frame_tick), 0);
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    pulse(8'h00, 320, 240);

    repeat (5) @(negedge Clk);
    check("sb_drain", exp_q.size(), 0);
    check("tick_count", tick_count, n_pulses);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
